// File: rtl/ascon_sequencer.sv
// ascon_sequencer: control FSM that drives the single-round Ascon permutation
// datapath (load, rounds, key XORs, absorb, squeeze) for AEAD/hash/XOF/CXOF.
module ascon_sequencer #(
    parameter int unsigned PA_ROUNDS     = 12,
    parameter int unsigned PB_ROUNDS     = 6,
    parameter int unsigned HASH_OUT_BLKS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] mode,
    input  logic       abort,
    input  logic       blk_valid,
    input  logic       blk_last,
    input  logic       sq_ready,
    input  logic       xof_stop,
    output logic [2:0] cur_mode,
    output logic       load_init,
    output logic       perm_en,
    output logic [3:0] rc_idx,
    output logic       key_xor_init,
    output logic       key_xor_final,
    output logic       absorb_en,
    output logic       blk_ready,
    output logic       out_valid,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [2:0] MODE_ENC  = 3'b001;
    localparam logic [2:0] MODE_DEC  = 3'b010;
    localparam logic [2:0] MODE_HASH = 3'b011;
    localparam logic [2:0] MODE_CXOF = 3'b101;

    localparam logic [3:0] CNT_PA   = 4'(PA_ROUNDS - 1);
    localparam logic [3:0] CNT_PB   = 4'(PB_ROUNDS - 1);
    localparam logic [3:0] LAST_OUT = 4'(HASH_OUT_BLKS - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_INIT_P,
        S_INIT_KX,
        S_ABSORB,
        S_PERM_B,
        S_FINAL_KX,
        S_FINAL_P,
        S_OUTPUT,
        S_SQ_P,
        S_DONE
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic [3:0] r_out_cnt;
    logic [3:0] w_out_cnt_nxt;
    logic [2:0] r_cur_mode;
    logic [2:0] w_mode_nxt;
    logic       r_err;
    logic       w_err_nxt;
    logic       w_aead;
    logic       w_mode_ok;

    assign w_aead    = (r_cur_mode == MODE_ENC) || (r_cur_mode == MODE_DEC);
    assign w_mode_ok = (mode >= MODE_ENC) && (mode <= MODE_CXOF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_out_cnt  <= '0;
            r_cur_mode <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_cnt      <= w_cnt_nxt;
            r_out_cnt  <= w_out_cnt_nxt;
            r_cur_mode <= w_mode_nxt;
            r_err      <= w_err_nxt;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_cnt_nxt     = r_cnt;
        w_out_cnt_nxt = r_out_cnt;
        w_mode_nxt    = r_cur_mode;
        w_err_nxt     = 1'b0;
        load_init     = 1'b0;
        perm_en       = 1'b0;
        key_xor_init  = 1'b0;
        key_xor_final = 1'b0;
        absorb_en     = 1'b0;
        blk_ready     = 1'b0;
        out_valid     = 1'b0;
        done          = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_mode_ok) begin
                        w_mode_nxt = mode;
                        w_next     = S_LOAD;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                load_init = 1'b1;
                w_cnt_nxt = CNT_PA;
                w_next    = S_INIT_P;
            end
            S_INIT_P: begin
                perm_en = 1'b1;
                if (r_cnt == '0) begin
                    w_next = w_aead ? S_INIT_KX : S_ABSORB;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_INIT_KX: begin
                key_xor_init = 1'b1;
                w_next       = S_ABSORB;
            end
            S_ABSORB: begin
                blk_ready = 1'b1;
                if (blk_valid) begin
                    absorb_en = 1'b1;
                    if (!blk_last) begin
                        w_cnt_nxt = w_aead ? CNT_PB : CNT_PA;
                        w_next    = S_PERM_B;
                    end else if (w_aead) begin
                        w_next = S_FINAL_KX;
                    end else begin
                        w_cnt_nxt = CNT_PA;
                        w_next    = S_FINAL_P;
                    end
                end
            end
            S_PERM_B: begin
                perm_en = 1'b1;
                if (r_cnt == '0) begin
                    w_next = S_ABSORB;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_FINAL_KX: begin
                key_xor_final = 1'b1;
                w_cnt_nxt     = CNT_PA;
                w_next        = S_FINAL_P;
            end
            S_FINAL_P, S_SQ_P: begin
                perm_en = 1'b1;
                if (r_cnt == '0) begin
                    w_next = S_OUTPUT;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_OUTPUT: begin
                out_valid = 1'b1;
                if (sq_ready) begin
                    if (w_aead) begin
                        w_next = S_DONE;
                    end else if (r_cur_mode == MODE_HASH) begin
                        // compare the pre-increment count: HASH_OUT_BLKS blocks in total
                        w_out_cnt_nxt = r_out_cnt + 4'd1;
                        if (r_out_cnt == LAST_OUT) begin
                            w_next = S_DONE;
                        end else begin
                            w_cnt_nxt = CNT_PA;
                            w_next    = S_SQ_P;
                        end
                    end else if (xof_stop) begin
                        w_next = S_DONE;
                    end else begin
                        w_cnt_nxt = CNT_PA;
                        w_next    = S_SQ_P;
                    end
                end
            end
            S_DONE: begin
                done          = !abort;
                w_out_cnt_nxt = '0;
                w_next        = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase

        if (abort) begin
            w_next        = S_IDLE;
            w_cnt_nxt     = '0;
            w_out_cnt_nxt = '0;
            w_mode_nxt    = r_cur_mode;
            w_err_nxt     = 1'b0;
        end
    end

    assign cur_mode = r_cur_mode;
    assign err      = r_err;
    assign busy     = (r_state != S_IDLE);
    assign rc_idx   = perm_en ? (4'd11 - r_cnt) : '0;

endmodule

// File: tb/tb_ascon_sequencer.sv
// Bench for ascon_sequencer: an event-sequence model of each operation feeds a
// scoreboard queue that a negedge monitor drains as the DUT raises strobes.
module tb_ascon_sequencer;

    localparam int PA = 12;
    localparam int PB = 6;
    localparam int HB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort, blk_valid, blk_last, sq_ready, xof_stop;
    logic [2:0] mode;
    logic [2:0] cur_mode;
    logic       load_init, perm_en, key_xor_init, key_xor_final;
    logic [3:0] rc_idx;
    logic       absorb_en, blk_ready, out_valid, busy, done, err;
    logic [15:0] allout;

    ascon_sequencer #(.PA_ROUNDS(PA), .PB_ROUNDS(PB), .HASH_OUT_BLKS(HB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .abort(abort),
        .blk_valid(blk_valid), .blk_last(blk_last), .sq_ready(sq_ready),
        .xof_stop(xof_stop), .cur_mode(cur_mode), .load_init(load_init),
        .perm_en(perm_en), .rc_idx(rc_idx), .key_xor_init(key_xor_init),
        .key_xor_final(key_xor_final), .absorb_en(absorb_en),
        .blk_ready(blk_ready), .out_valid(out_valid), .busy(busy),
        .done(done), .err(err)
    );

    assign allout = {cur_mode, load_init, perm_en, rc_idx, key_xor_init,
                     key_xor_final, absorb_en, blk_ready, out_valid, busy, done, err};

    always #5 clk = ~clk;

    typedef enum int {EV_LOAD, EV_PERM, EV_KXI, EV_ABS, EV_KXF, EV_OUT, EV_DONE, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       arg;
        int       cyc;
    } ev_t;

    ev_t expq[$];
    int  n_chk = 0;
    int  n_pass = 0;
    int  cyc = 0;
    bit  sb_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- reference model: ordered list of strobe events ----------
    function automatic void push(input ev_kind_t k, input int a, input int c);
        ev_t e;
        e.kind = k;
        e.arg  = a;
        e.cyc  = c;
        expq.push_back(e);
    endfunction

    // An N-round permutation uses the last N round constants of the 12.
    function automatic void push_rounds(input int n);
        for (int r = 0; r < n; r++) push(EV_PERM, 12 - n + r, -1);
    endfunction

    function automatic void model_op(input int m, input int nblk, input int nout,
                                     input int t0, input bit timed);
        bit aead;
        int base;
        aead = (m == 1) || (m == 2);
        base = expq.size();
        push(EV_LOAD, 0, -1);
        push_rounds(PA);
        if (aead) push(EV_KXI, 0, -1);
        for (int b = 0; b < nblk; b++) begin
            push(EV_ABS, (b == nblk - 1) ? 1 : 0, -1);
            if (b != nblk - 1) push_rounds(aead ? PB : PA);
        end
        if (aead) push(EV_KXF, 0, -1);
        push_rounds(PA);
        for (int o = 0; o < nout; o++) begin
            push(EV_OUT, 0, -1);
            if (o != nout - 1) push_rounds(PA);
        end
        push(EV_DONE, 0, -1);
        // with no stalls every event occupies exactly one consecutive cycle
        if (timed) for (int i = base; i < expq.size(); i++) expq[i].cyc = t0 + 1 + (i - base);
    endfunction

    // ---------------- monitor ----------------
    task automatic observe(input ev_kind_t k, input int a);
        ev_t e;
        if (expq.size() == 0) begin
            chk($sformatf("unexpected_%s", k.name()), int'(k), -1);
            return;
        end
        e = expq.pop_front();
        chk("event_kind", int'(k), int'(e.kind));
        chk($sformatf("%s_arg", k.name()), a, e.arg);
        if (e.cyc >= 0) chk($sformatf("%s_cycle", k.name()), cyc, e.cyc);
    endtask

    always @(negedge clk) begin
        int ns;
        if (rst_n && sb_on) begin
            ns = int'(load_init) + int'(perm_en) + int'(key_xor_init) +
                 int'(key_xor_final) + int'(absorb_en);
            if (ns != 0) chk("strobes_exclusive", (ns <= 1) ? 1 : 0, 1);
            if (absorb_en) chk("absorb_needs_ready", int'(blk_ready), 1);
            if (load_init)     observe(EV_LOAD, 0);
            if (perm_en)       observe(EV_PERM, int'(rc_idx));
            if (key_xor_init)  observe(EV_KXI, 0);
            if (absorb_en)     observe(EV_ABS, int'(blk_last));
            if (key_xor_final) observe(EV_KXF, 0);
            if (out_valid && sq_ready) observe(EV_OUT, 0);
            if (done)          observe(EV_DONE, 0);
            if (err)           observe(EV_ERR, 0);
        end
    end

    // ---------------- drivers ----------------
    task automatic blk_drv(input int nblk, input bit pre, input int first_gap, input int gmax);
        for (int i = 0; i < nblk; i++) begin
            int t;
            int g;
            if (!(pre && i == 0)) begin
                g = (i == 0 && first_gap >= 0) ? first_gap : int'($urandom_range(gmax, 0));
                t = 0;
                do begin @(negedge clk); t++; end while (!blk_ready && t < 3000);
                if (t >= 3000) begin chk("blk_ready_timeout", 0, 1); return; end
                for (int k = 0; k < g; k++) begin
                    @(negedge clk);
                    chk("blk_ready_held", int'(blk_ready), 1);
                    chk("no_absorb_while_idle_input", int'(absorb_en), 0);
                end
                @(posedge clk); #1;
                blk_valid = 1'b1;
                blk_last  = (i == nblk - 1);
            end
            t = 0;
            do begin @(negedge clk); t++; end while (!(blk_ready && blk_valid) && t < 3000);
            if (t >= 3000) begin chk("blk_handshake_timeout", 0, 1); return; end
            @(posedge clk); #1;
            blk_valid = 1'b0;
            blk_last  = 1'b0;
        end
    endtask

    task automatic sq_drv(input int nout, input bit always_rdy, input int fixed_gap, input int gmax);
        if (always_rdy) begin
            sq_ready = 1'b1;
            return;
        end
        for (int j = 0; j < nout; j++) begin
            int t;
            int g;
            g = (fixed_gap >= 0) ? fixed_gap : int'($urandom_range(gmax, 0));
            t = 0;
            do begin @(negedge clk); t++; end while (!out_valid && t < 3000);
            if (t >= 3000) begin chk("out_valid_timeout", 0, 1); return; end
            for (int k = 0; k < g; k++) begin
                @(negedge clk);
                chk("out_valid_held", int'(out_valid), 1);
            end
            @(posedge clk); #1;
            sq_ready = 1'b1;
            xof_stop = (j == nout - 1);
            @(posedge clk); #1;
            sq_ready = 1'b0;
            xof_stop = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((expq.size() != 0 || busy) && t < 3000) begin @(negedge clk); t++; end
        chk("op_completes", (t < 3000) ? 1 : 0, 1);
        chk("queue_drained", expq.size(), 0);
        expq.delete();
    endtask

    task automatic run_op(input int m, input int nblk, input int nout, input bit pre,
                          input int fgap, input int bgmax, input bit sq_always,
                          input int sgap, input int sgmax, input bit timed);
        @(posedge clk); #1;
        model_op(m, nblk, nout, cyc, timed);
        mode  = 3'(m);
        start = 1'b1;
        if (pre) begin
            blk_valid = 1'b1;
            blk_last  = (nblk == 1);
        end
        @(posedge clk); #1;
        start = 1'b0;
        mode  = 3'($urandom);
        fork
            blk_drv(nblk, pre, fgap, bgmax);
            sq_drv(nout, sq_always, sgap, sgmax);
        join
        wait_idle();
        chk("cur_mode_latched", int'(cur_mode), m);
        sq_ready = 1'b0;
        xof_stop = 1'b0;
        mode     = 3'b000;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int t;
        rst_n = 1'b0;
        {start, abort, blk_valid, blk_last, sq_ready, xof_stop} = '0;
        mode = 3'b000;

        // reset held with inputs toggling: every output stays 0
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            {start, abort, blk_valid, blk_last, sq_ready, xof_stop} = 6'($urandom);
            mode = 3'($urandom);
            @(negedge clk);
            chk("reset_outputs_zero", int'(allout), 0);
        end
        {start, abort, blk_valid, blk_last, sq_ready, xof_stop} = '0;
        mode = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_not_busy", int'(busy), 0);
        chk("idle_outputs_zero", int'(allout), 0);
        sb_on = 1'b1;

        // AEAD enc, single block waiting, consumer always ready: exact timeline
        run_op(1, 1, 1, 1'b1, -1, 0, 1'b1, 0, 0, 1'b1);
        // hash, 3 blocks, sq_ready held high: 4 squeeze blocks
        run_op(3, 3, HB, 1'b0, 0, 0, 1'b1, 0, 0, 1'b0);
        // AEAD dec, 2 blocks, first block delayed
        run_op(2, 2, 1, 1'b0, 4, 0, 1'b1, 0, 0, 1'b0);
        // XOF, stop on 3rd block, consumer stalls 3 cycles each block
        run_op(4, 2, 3, 1'b0, -1, 2, 1'b0, 3, 0, 1'b0);

        // invalid modes raise err for one cycle and never leave IDLE
        for (int k = 0; k < 3; k++) begin
            int bad;
            bad = (k == 0) ? 0 : ((k == 1) ? 6 : 7);
            @(posedge clk); #1;
            push(EV_ERR, 0, cyc + 1);
            mode  = 3'(bad);
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            mode  = 3'b000;
            @(negedge clk);
            chk("err_busy_low", int'(busy), 0);
            @(negedge clk);
            chk("err_single_cycle", int'(err), 0);
            chk("err_busy_still_low", int'(busy), 0);
            chk("err_event_seen", expq.size(), 0);
            expq.delete();
        end

        // abort in the middle of INIT_P
        sb_on = 1'b0;
        @(posedge clk); #1;
        mode = 3'b001; start = 1'b1; blk_valid = 1'b1; blk_last = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_precond_perm", int'(perm_en), 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_idle_busy", int'(busy), 0);
        chk("abort_idle_perm", int'(perm_en), 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("abort_no_done", seen, 0);
        blk_valid = 1'b0; blk_last = 1'b0;

        // asynchronous reset during FINAL_P
        @(posedge clk); #1;
        mode = 3'b001; start = 1'b1; blk_valid = 1'b1; blk_last = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (!key_xor_final && t < 200);
        chk("final_kx_reached", int'(key_xor_final), 1);
        repeat (5) @(negedge clk);
        chk("final_p_perm", int'(perm_en), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs_zero", int'(allout), 0);
        blk_valid = 1'b0; blk_last = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_reset_idle", int'(allout), 0);
        sb_on = 1'b1;

        // randomized operations in every legal mode
        for (int n = 0; n < 14; n++) begin
            int m;
            int nb;
            int no;
            bit always_rdy;
            m  = int'($urandom_range(5, 1));
            nb = int'($urandom_range(4, 1));
            no = (m == 3) ? HB : ((m >= 4) ? int'($urandom_range(4, 1)) : 1);
            always_rdy = (m <= 3) ? 1'($urandom) : 1'b0;
            run_op(m, nb, no, 1'b0, -1, 3, always_rdy, -1, 3, 1'b0);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
